// File: rtl/plab3_mem_guard_pkg.sv
// Shared definitions for the memory guard port: FSM encodings, domain codes,
// memory message layout helpers and the default secret-region base.

`ifndef PLAB3_MEM_GUARD_PKG_SV
`define PLAB3_MEM_GUARD_PKG_SV

// Request layout (MSB..LSB): type[3] | opaque[o] | addr[a] | len[log2(d/8)] | data[d]
// Response layout (MSB..LSB): type[3] | opaque[o] | len[log2(d/8)] | data[d]
`define PLAB3_MEM_LEN_NBITS(d)              ($clog2((d)/8))
`define PLAB3_MEM_REQ_NBITS(o,a,d)          (3 + (o) + (a) + `PLAB3_MEM_LEN_NBITS(d) + (d))
`define PLAB3_MEM_RESP_NBITS(o,d)           (3 + (o) + `PLAB3_MEM_LEN_NBITS(d) + (d))
`define PLAB3_MEMREQ_TYPE(msg,o,a,d)        msg[(o) + (a) + `PLAB3_MEM_LEN_NBITS(d) + (d) +: 3]
`define PLAB3_MEMREQ_OPAQUE(msg,o,a,d)      msg[(a) + `PLAB3_MEM_LEN_NBITS(d) + (d) +: (o)]
`define PLAB3_MEMREQ_ADDR(msg,a,d)          msg[`PLAB3_MEM_LEN_NBITS(d) + (d) +: (a)]

package plab3_mem_guard_pkg;

    localparam logic [2:0] STATE_IDLE = 3'd0;
    localparam logic [2:0] STATE_FWD  = 3'd1;
    localparam logic [2:0] STATE_WAIT = 3'd2;
    localparam logic [2:0] STATE_RESP = 3'd3;
    localparam logic [2:0] STATE_DENY = 3'd4;

    localparam logic DOMAIN_LOW  = 1'b0;
    localparam logic DOMAIN_HIGH = 1'b1;

    localparam logic [31:0] PLAB3_HIGH_BASE_DEFAULT = 32'h0000_8000;

    typedef enum logic [2:0] {
        MEM_TYPE_READ  = 3'd0,
        MEM_TYPE_WRITE = 3'd1
    } mem_type_e;

endpackage

`endif

// File: rtl/plab3_mem_guard_port_check.sv
// Combinational partition check: a low-domain access at or above the
// high-region base is a violation.

module plab3_mem_guard_port_check
    import plab3_mem_guard_pkg::*;
#(
    parameter int unsigned     abw         = 32,
    parameter logic [abw-1:0]  p_high_base = abw'(PLAB3_HIGH_BASE_DEFAULT)
)(
    input  logic           domain,
    input  logic [abw-1:0] addr,
    output logic           violation
);

    // Unsigned full-width compare; the high domain may reach every address.
    assign violation = (domain == DOMAIN_LOW) && (addr >= p_high_base);

endmodule

// File: rtl/plab3_mem_guard_port.sv
// Security guard between the L1 cache memory port and main memory. Optional
// denial counter is compiled in with PLAB3_MEM_GUARD_STATS_EN.

module plab3_mem_guard_port
    import plab3_mem_guard_pkg::*;
#(
    parameter int unsigned     p_opaque_nbits = 8,
    parameter int unsigned     abw            = 32,
    parameter int unsigned     clw            = 128,
    parameter logic [abw-1:0]  p_high_base    = abw'(PLAB3_HIGH_BASE_DEFAULT)
)(
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   domain,

    input  logic [`PLAB3_MEM_REQ_NBITS(p_opaque_nbits,abw,clw)-1:0] cache_memreq_msg,
    input  logic                                                   cache_memreq_val,
    output logic                                                   cache_memreq_rdy,

    output logic [`PLAB3_MEM_RESP_NBITS(p_opaque_nbits,clw)-1:0]    cache_memresp_msg,
    output logic                                                   cache_memresp_val,
    input  logic                                                   cache_memresp_rdy,
    output logic                                                   fail,

    output logic [`PLAB3_MEM_REQ_NBITS(p_opaque_nbits,abw,clw)-1:0] memreq_msg,
    output logic                                                   memreq_val,
    input  logic                                                   memreq_rdy,

    input  logic [`PLAB3_MEM_RESP_NBITS(p_opaque_nbits,clw)-1:0]    memresp_msg,
    input  logic                                                   memresp_val,
    output logic                                                   memresp_rdy
`ifdef PLAB3_MEM_GUARD_STATS_EN
    ,
    input  logic                                                   deny_clear,
    output logic [15:0]                                            deny_count
`endif
);

    localparam int unsigned LEN_NBITS  = `PLAB3_MEM_LEN_NBITS(clw);
    localparam int unsigned REQ_NBITS  = `PLAB3_MEM_REQ_NBITS(p_opaque_nbits, abw, clw);
    localparam int unsigned RESP_NBITS = `PLAB3_MEM_RESP_NBITS(p_opaque_nbits, clw);

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [REQ_NBITS-1:0]  req_reg;
    logic [RESP_NBITS-1:0] resp_reg;
    logic                  violation;
    logic [RESP_NBITS-1:0] deny_msg;

    plab3_mem_guard_port_check #(
        .abw         (abw),
        .p_high_base (p_high_base)
    ) u_check (
        .domain    (domain),
        .addr      (`PLAB3_MEMREQ_ADDR(cache_memreq_msg, abw, clw)),
        .violation (violation)
    );

    // The check runs on the incoming message and domain at the accept edge,
    // which is exactly what gets latched into req_reg on that same edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE_IDLE: if (cache_memreq_val) state_next = violation ? STATE_DENY : STATE_FWD;
            STATE_FWD:  if (memreq_rdy)        state_next = STATE_WAIT;
            STATE_WAIT: if (memresp_val)       state_next = STATE_RESP;
            STATE_RESP: if (cache_memresp_rdy) state_next = STATE_IDLE;
            STATE_DENY: if (cache_memresp_rdy) state_next = STATE_IDLE;
            default:                           state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= STATE_IDLE;
            req_reg   <= '0;
            resp_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == STATE_IDLE && cache_memreq_val)
                req_reg <= cache_memreq_msg;
            if (state_reg == STATE_WAIT && memresp_val)
                resp_reg <= memresp_msg;
        end
    end

    // Denials echo type and opaque but never leak length or data.
    assign deny_msg = {`PLAB3_MEMREQ_TYPE(req_reg, p_opaque_nbits, abw, clw),
                       `PLAB3_MEMREQ_OPAQUE(req_reg, p_opaque_nbits, abw, clw),
                       {LEN_NBITS{1'b0}},
                       {clw{1'b0}}};

    // Every handshake output is forced low while reset is held.
    assign cache_memreq_rdy  = reset && (state_reg == STATE_IDLE);
    assign memreq_val        = reset && (state_reg == STATE_FWD);
    assign memresp_rdy       = reset && (state_reg == STATE_WAIT);
    assign cache_memresp_val = reset && ((state_reg == STATE_RESP) || (state_reg == STATE_DENY));
    assign fail              = reset && (state_reg == STATE_DENY);
    assign memreq_msg        = req_reg;
    assign cache_memresp_msg = (state_reg == STATE_DENY) ? deny_msg : resp_reg;

`ifdef PLAB3_MEM_GUARD_STATS_EN
    logic [15:0] deny_count_reg;

    always_ff @(posedge clk) begin
        if (!reset)
            deny_count_reg <= '0;
        else if (deny_clear)
            deny_count_reg <= '0;
        else if (state_reg == STATE_DENY && cache_memresp_rdy && deny_count_reg != 16'hFFFF)
            deny_count_reg <= deny_count_reg + 16'd1;
    end

    assign deny_count = deny_count_reg;
`endif

endmodule

// File: tb/tb_plab3_mem_guard_port.sv
// Directed self-checking bench for plab3_mem_guard_port; covers the denial
// counter too when PLAB3_MEM_GUARD_STATS_EN is defined.

module tb_plab3_mem_guard_port;

    localparam int O    = 8;
    localparam int A    = 32;
    localparam int D    = 128;
    localparam int L    = 4;
    localparam int REQW = 3 + O + A + L + D;
    localparam int RSPW = 3 + O + L + D;
    localparam logic [2:0] T_RD = 3'd0;
    localparam logic [2:0] T_WR = 3'd1;

    logic            clk = 1'b0;
    logic            reset;
    logic            domain;
    logic [REQW-1:0] cache_memreq_msg;
    logic            cache_memreq_val;
    logic            cache_memreq_rdy;
    logic [RSPW-1:0] cache_memresp_msg;
    logic            cache_memresp_val;
    logic            cache_memresp_rdy;
    logic            fail;
    logic [REQW-1:0] memreq_msg;
    logic            memreq_val;
    logic            memreq_rdy;
    logic [RSPW-1:0] memresp_msg;
    logic            memresp_val;
    logic            memresp_rdy;
`ifdef PLAB3_MEM_GUARD_STATS_EN
    logic            deny_clear;
    logic [15:0]     deny_count;
`endif

    int errors = 0;
    int checks = 0;
    int fwd_count = 0;

    always #5 clk = ~clk;

    plab3_mem_guard_port dut (
        .clk               (clk),
        .reset             (reset),
        .domain            (domain),
        .cache_memreq_msg  (cache_memreq_msg),
        .cache_memreq_val  (cache_memreq_val),
        .cache_memreq_rdy  (cache_memreq_rdy),
        .cache_memresp_msg (cache_memresp_msg),
        .cache_memresp_val (cache_memresp_val),
        .cache_memresp_rdy (cache_memresp_rdy),
        .fail              (fail),
        .memreq_msg        (memreq_msg),
        .memreq_val        (memreq_val),
        .memreq_rdy        (memreq_rdy),
        .memresp_msg       (memresp_msg),
        .memresp_val       (memresp_val),
        .memresp_rdy       (memresp_rdy)
`ifdef PLAB3_MEM_GUARD_STATS_EN
        ,
        .deny_clear        (deny_clear),
        .deny_count        (deny_count)
`endif
    );

    always @(posedge clk) begin
        if (memreq_val && memreq_rdy)
            fwd_count <= fwd_count + 1;
    end

    function automatic logic [REQW-1:0] mk_req(logic [2:0] t, logic [7:0] op, logic [31:0] addr,
                                               logic [3:0] len, logic [127:0] data);
        return {t, op, addr, len, data};
    endfunction

    function automatic logic [RSPW-1:0] mk_resp(logic [2:0] t, logic [7:0] op, logic [3:0] len,
                                                logic [127:0] data);
        return {t, op, len, data};
    endfunction

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Legal transaction: accept, optional memreq stall, memory delay, response.
    task automatic fwd_txn(string name, logic [2:0] t, logic [7:0] op, logic [31:0] addr,
                           logic [127:0] wdata, logic dom, int mem_delay, logic [127:0] rdata);
        logic [REQW-1:0] req;
        logic [RSPW-1:0] rsp;
        int              fwd_before;
        req = mk_req(t, op, addr, 4'd0, wdata);
        rsp = mk_resp(t, op, 4'd0, rdata);
        fwd_before = fwd_count;
        cache_memreq_val = 1'b1; cache_memreq_msg = req; domain = dom;
        #1 chk({name, ".accept_rdy"}, 256'(cache_memreq_rdy), 256'(1));
        step();
        cache_memreq_val = 1'b0; domain = ~dom; cache_memreq_msg = '1;
        #1 chk({name, ".memreq_val"}, 256'(memreq_val), 256'(1));
        chk({name, ".memreq_msg"}, 256'(memreq_msg), 256'(req));
        chk({name, ".fwd_busy"}, 256'(cache_memreq_rdy), 256'(0));
        step();
        chk({name, ".memreq_hold"}, 256'({memreq_val, memreq_msg}), 256'({1'b1, req}));
        memreq_rdy = 1'b1;
        step();
        memreq_rdy = 1'b0;
        #1 chk({name, ".wait_rdy"}, 256'({memresp_rdy, memreq_val}), 256'({1'b1, 1'b0}));
        for (int i = 1; i < mem_delay; i++) step();
        memresp_val = 1'b1; memresp_msg = rsp;
        step();
        memresp_val = 1'b0; memresp_msg = '0;
        #1 chk({name, ".resp"}, 256'({cache_memresp_val, fail, cache_memresp_msg}),
               256'({1'b1, 1'b0, rsp}));
        cache_memresp_rdy = 1'b1;
        step();
        cache_memresp_rdy = 1'b0;
        #1 chk({name, ".idle"}, 256'({cache_memreq_rdy, cache_memresp_val}), 256'({1'b1, 1'b0}));
        chk({name, ".fwd_once"}, 256'(fwd_count), 256'(fwd_before + 1));
        $display("txn %s type=%0d addr=%08h dom=%0d forwarded", name, t, addr, dom);
    endtask

    // Denied transaction with `hold` cycles of response backpressure.
    task automatic deny_txn(string name, logic [2:0] t, logic [7:0] op, logic [31:0] addr,
                            int hold, logic clr);
        logic [RSPW-1:0] rsp;
        int              fwd_before;
        rsp = mk_resp(t, op, 4'd0, 128'd0);
        fwd_before = fwd_count;
        cache_memreq_val = 1'b1; domain = 1'b0;
        cache_memreq_msg = mk_req(t, op, addr, 4'hF, {4{32'hDEAD_BEEF}});
        #1 chk({name, ".accept_rdy"}, 256'(cache_memreq_rdy), 256'(1));
        step();
        cache_memreq_val = 1'b0; domain = 1'b1;
        for (int i = 0; i <= hold; i++) begin
            #1 chk({name, ".deny"}, 256'({cache_memresp_val, fail, cache_memresp_msg}),
                   256'({1'b1, 1'b1, rsp}));
            chk({name, ".blocked"}, 256'({cache_memreq_rdy, memreq_val}), 256'(0));
            if (i < hold) step();
        end
        cache_memresp_rdy = 1'b1;
`ifdef PLAB3_MEM_GUARD_STATS_EN
        deny_clear = clr;
`endif
        step();
        cache_memresp_rdy = 1'b0;
`ifdef PLAB3_MEM_GUARD_STATS_EN
        deny_clear = 1'b0;
`endif
        #1 chk({name, ".idle"}, 256'({cache_memreq_rdy, cache_memresp_val, fail}),
               256'({1'b1, 1'b0, 1'b0}));
        chk({name, ".not_fwd"}, 256'(fwd_count), 256'(fwd_before));
        $display("txn %s type=%0d addr=%08h dom=0 denied clr=%0d", name, t, addr, clr);
    endtask

    initial begin
        reset = 1'b0; domain = 1'b0;
        cache_memreq_msg = '0; cache_memreq_val = 1'b0; cache_memresp_rdy = 1'b0;
        memreq_rdy = 1'b0; memresp_msg = '0; memresp_val = 1'b0;
`ifdef PLAB3_MEM_GUARD_STATS_EN
        deny_clear = 1'b0;
`endif
        step();
        step();
        chk("reset.outs", 256'({cache_memreq_rdy, memreq_val, memresp_rdy, cache_memresp_val, fail}),
            256'(0));
        chk("reset.resp_msg", 256'(cache_memresp_msg), 256'(0));
        reset = 1'b1;
        #1 chk("reset.idle_rdy", 256'(cache_memreq_rdy), 256'(1));
        $display("txn reset released");

        fwd_txn("rd_low", T_RD, 8'h11, 32'h0000_0100, 128'd0, 1'b0, 3, {16{8'hA5}});
        fwd_txn("rd_edge", T_RD, 8'h12, 32'h0000_7FFF, 128'd0, 1'b0, 1, {4{32'h1234_5678}});
        fwd_txn("wr_high", T_WR, 8'h33, 32'h0000_9000, {4{32'hCAFE_F00D}}, 1'b1, 2, 128'd0);

        deny_txn("rd_deny", T_RD, 8'h22, 32'h0000_8000, 0, 1'b0);
        deny_txn("rd_deny_bp", T_RD, 8'h44, 32'h0000_8000, 5, 1'b0);
        deny_txn("wr_deny_top", T_WR, 8'h55, 32'hFFFF_FFFF, 1, 1'b0);

        // Abandon a transaction in WAIT and make sure the late response is dropped.
        cache_memreq_val = 1'b1; domain = 1'b0;
        cache_memreq_msg = mk_req(T_RD, 8'h66, 32'h0000_0200, 4'd0, 128'd0);
        step();
        cache_memreq_val = 1'b0; memreq_rdy = 1'b1;
        step();
        memreq_rdy = 1'b0;
        #1 chk("rst_wait.memresp_rdy", 256'(memresp_rdy), 256'(1));
        reset = 1'b0;
        #1 chk("rst_wait.in_reset", 256'({cache_memreq_rdy, memresp_rdy}), 256'(0));
        step();
        reset = 1'b1; memresp_val = 1'b1;
        memresp_msg = mk_resp(T_RD, 8'h66, 4'd0, {16{8'h5A}});
        #1 chk("rst_wait.ignored", 256'({memresp_rdy, cache_memreq_rdy}), 256'({1'b0, 1'b1}));
        step();
        memresp_val = 1'b0;
        #1 chk("rst_wait.no_resp", 256'({cache_memresp_val, cache_memreq_rdy}), 256'({1'b0, 1'b1}));
        $display("txn reset_in_wait abandoned");

`ifdef PLAB3_MEM_GUARD_STATS_EN
        deny_clear = 1'b1;
        step();
        deny_clear = 1'b0;
        #1 chk("stats.cleared", 256'(deny_count), 256'(0));
        for (int i = 0; i < 3; i++)
            deny_txn("stats_deny", T_RD, 8'(i), 32'h0001_0000, 0, 1'b0);
        chk("stats.three", 256'(deny_count), 256'(3));
        deny_txn("stats_clr", T_RD, 8'h77, 32'h0001_0000, 0, 1'b1);
        chk("stats.clear_prio", 256'(deny_count), 256'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
